// File: rtl/mem_store_checker.sv
// mem_store_checker: snoops the data-memory write bus and checks each store
// against an ordered list of expected stores held in a small FIFO.
// The verdict (pass/fail) is sticky until reset; on a failure the offending
// address/data and a reason code are captured for diagnosis.
//
// Handshake: exp_valid is a one-cycle push strobe with no ready. While
// exp_full is high in IDLE, a push is dropped and exp_ovf is set. Stores on
// the bus are qualified by memwrite != 0 and are always accepted (no
// backpressure); every such cycle is checked while in CHECK.
module mem_store_checker #(
  parameter int DEPTH   = 8,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1024,
  parameter int STRICT  = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           exp_valid,
  input  logic [AW-1:0]                  exp_adr,
  input  logic [DW-1:0]                  exp_data,
  input  logic [1:0]                     exp_size,
  output logic                           exp_full,
  output logic                           exp_ovf,
  input  logic                           start,
  input  logic [1:0]                     memwrite,
  input  logic [AW-1:0]                  dataadr,
  input  logic [DW-1:0]                  writedata,
  output logic                           done,
  output logic                           pass,
  output logic                           fail,
  output logic [2:0]                     fail_code,
  output logic [$clog2(DEPTH+1)-1:0]     match_cnt,
  output logic [AW-1:0]                  fail_adr,
  output logic [DW-1:0]                  fail_data
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [2:0] CODE_NONE    = 3'd0;
  localparam logic [2:0] CODE_ADDR    = 3'd1;
  localparam logic [2:0] CODE_DATA    = 3'd2;
  localparam logic [2:0] CODE_SIZE    = 3'd3;
  localparam logic [2:0] CODE_TIMEOUT = 3'd4;
  localparam logic [2:0] CODE_EMPTY   = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_PASS  = 2'd2,
    S_FAIL  = 2'd3
  } state_t;

  // Expected-store storage (no reset: emptiness is tracked by count_q).
  logic [AW-1:0] adr_mem  [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [1:0]    size_mem [DEPTH];

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] match_q, match_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [2:0]    code_q, code_d;
  logic [AW-1:0] fadr_q, fadr_d;
  logic [DW-1:0] fdata_q, fdata_d;
  logic          push;

  logic [AW-1:0] head_adr;
  logic [DW-1:0] head_data;
  logic [1:0]    head_size;
  logic [DW-1:0] head_mask;
  logic          addr_eq, size_eq, data_eq, store_seen, hit;
  logic [TW-1:0] tcnt_inc;
  logic          timeout_hit;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Head-of-FIFO compare against the bus; data above the access size is ignored.
  always_comb begin
    head_adr  = adr_mem[rd_ptr_q];
    head_data = data_mem[rd_ptr_q];
    head_size = size_mem[rd_ptr_q];
    case (head_size)
      2'b01:   head_mask = DW'(8'hFF);
      2'b10:   head_mask = DW'(16'hFFFF);
      default: head_mask = '1;
    endcase
    store_seen  = (memwrite != 2'b00);
    addr_eq     = (dataadr == head_adr);
    size_eq     = (memwrite == head_size);
    data_eq     = (((writedata ^ head_data) & head_mask) == '0);
    hit         = store_seen && addr_eq && size_eq && data_eq;
    tcnt_inc    = tcnt_q + 1'b1;
    timeout_hit = (TIMEOUT != 0) && (tcnt_inc == TW'(TIMEOUT));
  end

  // Next-state logic for the checker FSM, FIFO pointers and verdict capture.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    match_d  = match_q;
    tcnt_d   = tcnt_q;
    code_d   = code_q;
    fadr_d   = fadr_q;
    fdata_d  = fdata_q;
    push     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // The push is resolved before start so a same-cycle load counts.
        if (exp_valid) begin
          if (count_q == CW'(DEPTH)) begin
            ovf_d = 1'b1;
          end else begin
            push     = 1'b1;
            wr_ptr_d = ptr_next(wr_ptr_q);
            count_d  = count_q + 1'b1;
          end
        end
        if (start) begin
          if (count_d == '0) begin
            state_d = S_FAIL;
            code_d  = CODE_EMPTY;
          end else begin
            state_d = S_CHECK;
            tcnt_d  = '0;
          end
        end
      end
      S_CHECK: begin
        if (hit) begin
          rd_ptr_d = ptr_next(rd_ptr_q);
          count_d  = count_q - 1'b1;
          match_d  = match_q + 1'b1;
          tcnt_d   = '0;
          if (count_q == CW'(1)) state_d = S_PASS;
        end else if (store_seen && ((STRICT != 0) || !addr_eq)) begin
          state_d = S_FAIL;
          code_d  = !addr_eq ? CODE_ADDR : (!size_eq ? CODE_SIZE : CODE_DATA);
          fadr_d  = dataadr;
          fdata_d = writedata;
        end else begin
          // No progress this cycle (idle bus or a tolerated lenient retry).
          tcnt_d = tcnt_inc;
          if (timeout_hit) begin
            state_d = S_FAIL;
            code_d  = CODE_TIMEOUT;
            fadr_d  = '0;
            fdata_d = '0;
          end
        end
      end
      default: ; // PASS and FAIL hold until reset
    endcase
  end

  // State and control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      match_q  <= '0;
      tcnt_q   <= '0;
      code_q   <= CODE_NONE;
      fadr_q   <= '0;
      fdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      match_q  <= match_d;
      tcnt_q   <= tcnt_d;
      code_q   <= code_d;
      fadr_q   <= fadr_d;
      fdata_q  <= fdata_d;
    end
  end

  // Expected-store writes into the FIFO storage.
  always_ff @(posedge clk) begin
    if (push) begin
      adr_mem[wr_ptr_q]  <= exp_adr;
      data_mem[wr_ptr_q] <= exp_data;
      size_mem[wr_ptr_q] <= exp_size;
    end
  end

  assign exp_full  = (count_q == CW'(DEPTH));
  assign exp_ovf   = ovf_q;
  assign pass      = (state_q == S_PASS);
  assign fail      = (state_q == S_FAIL);
  assign done      = pass | fail;
  assign fail_code = code_q;
  assign match_cnt = match_q;
  assign fail_adr  = fadr_q;
  assign fail_data = fdata_q;

endmodule
